// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_P    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic p;
        logic d;
    } rsp_tag_t;

    localparam logic [2:0] FUNC3_WORD = 3'b010;

    // Round-robin contention: the requester that did not win last takes the port.
    function automatic logic rr_d_wins(arb_state_e last);
        return last == ARB_P;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_wait_counter.sv
// Saturating wait counter: clear has priority over increment; at_max_o flags saturation.
module dmem_port_arbiter_wait_counter #(
    parameter int unsigned MaxCount = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);
    localparam int unsigned CntW = $clog2(MaxCount + 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    assign at_max_o = (cnt_q == CntW'(MaxCount));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the MEM stage (P) and a debug/DMA loader (D).
// Define DMEM_ARB_RR_EN for round-robin contention; default is fixed P priority with bounded D wait.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  p_rd_i,
    input  logic                  p_wr_i,
    input  logic [DM_ADDRESS-1:0] p_addr_i,
    input  logic [DATA_W-1:0]     p_wdata_i,
    input  logic [2:0]            p_func3_i,
    output logic                  p_stall_o,
    output logic                  p_rvalid_o,
    input  logic                  d_valid_i,
    input  logic                  d_we_i,
    input  logic [DM_ADDRESS-1:0] d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    output logic                  d_ready_o,
    output logic                  d_rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic [DM_ADDRESS-1:0] mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [2:0]            mem_func3_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);
    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [DM_ADDRESS-1:0] addr;
        logic [DATA_W-1:0]     wdata;
        logic [2:0]            func3;
    } dmem_req_t;

    arb_state_e state_d, state_q;
    rsp_tag_t   tag_d, tag_q;
    dmem_req_t  p_req_s, d_req_s, mem_req;
    logic       p_req, d_wins, grant_p, grant_d, at_max;

    assign p_req = p_rd_i | p_wr_i;

    // A simultaneous rd+wr from P is illegal and resolved as a write.
    always_comb begin
        p_req_s = '{rd: p_rd_i & ~p_wr_i, wr: p_wr_i, addr: p_addr_i,
                    wdata: p_wdata_i, func3: p_func3_i};
        d_req_s = '{rd: ~d_we_i, wr: d_we_i, addr: d_addr_i,
                    wdata: d_wdata_i, func3: FUNC3_WORD};
    end

    always_comb begin
        d_wins = at_max;
`ifdef DMEM_ARB_RR_EN
        if (!at_max) begin
            d_wins = rr_d_wins(state_q);
        end
`endif
    end

    assign grant_p = p_req & (~d_valid_i | ~d_wins);
    assign grant_d = d_valid_i & (~p_req | d_wins);

    // Outputs are forced quiet while reset is held; next-state logic stays reset-free.
    always_comb begin
        mem_req = '0;
        if (rst_ni) begin
            if (grant_p) begin
                mem_req = p_req_s;
            end else if (grant_d) begin
                mem_req = d_req_s;
            end
        end
    end

    assign mem_rd_o    = mem_req.rd;
    assign mem_wr_o    = mem_req.wr;
    assign mem_addr_o  = mem_req.addr;
    assign mem_wdata_o = mem_req.wdata;
    assign mem_func3_o = mem_req.func3;
    assign p_stall_o   = rst_ni & p_req & ~grant_p;
    assign d_ready_o   = rst_ni & grant_d;
    assign p_rvalid_o  = tag_q.p;
    assign d_rvalid_o  = tag_q.d;
    assign rdata_o     = mem_rdata_i;

    always_comb begin
        state_d = state_q;
        if (grant_p) begin
            state_d = ARB_P;
        end else if (grant_d) begin
            state_d = ARB_D;
        end
        tag_d = '{p: grant_p & p_req_s.rd, d: grant_d & d_req_s.rd};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    dmem_port_arbiter_wait_counter #(
        .MaxCount (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (~d_valid_i | grant_d),
        .inc_i    (d_valid_i & ~grant_d),
        .at_max_o (at_max)
    );

    p_rd_wr_exclusive_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(p_rd_i && p_wr_i));
    state_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q inside {ARB_IDLE, ARB_P, ARB_D});

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed table, corner sequences, random vs. model.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int MW = 8;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit            p_rd;
        bit            p_wr;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        logic [2:0]    p_f3;
        bit            d_valid;
        bit            d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
    } stim_t;

    typedef struct {
        stim_t s;
        bit    stall;
        bit    ready;
        bit    mrd;
        bit    mwr;
        bit    prv;
        bit    drv;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic p_rd, p_wr, p_stall, p_rvalid, d_valid, d_we, d_ready, d_rvalid, mem_rd, mem_wr;
    logic [AW-1:0] p_addr, d_addr, mem_addr;
    logic [DW-1:0] p_wdata, d_wdata, rdata, mem_wdata, mem_rdata;
    logic [2:0] p_func3, mem_func3;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int            m_wait;   // consecutive cycles D has been left waiting
    int            m_last;   // 0 none yet, 1 P, 2 D
    bit            m_tp, m_td, m_gd;
    logic [DW-1:0] m_rdata;
    bit            obs_ready, obs_stall, obs_prv;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_rd ? mem[mem_addr] : $urandom;
    end

    dmem_port_arbiter #(
        .DATA_W     (DW),
        .DM_ADDRESS (AW),
        .MAX_WAIT   (MW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .p_rd_i      (p_rd),
        .p_wr_i      (p_wr),
        .p_addr_i    (p_addr),
        .p_wdata_i   (p_wdata),
        .p_func3_i   (p_func3),
        .p_stall_o   (p_stall),
        .p_rvalid_o  (p_rvalid),
        .d_valid_i   (d_valid),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_ready_o   (d_ready),
        .d_rvalid_o  (d_rvalid),
        .rdata_o     (rdata),
        .mem_rd_o    (mem_rd),
        .mem_wr_o    (mem_wr),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_func3_o (mem_func3),
        .mem_rdata_i (mem_rdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0;
        m_last = 0;
        m_tp = 0;
        m_td = 0;
        m_gd = 0;
    endtask

    task automatic drive(input stim_t s);
        p_rd = s.p_rd;       p_wr = s.p_wr;       p_addr = s.p_addr;
        p_wdata = s.p_wdata; p_func3 = s.p_f3;
        d_valid = s.d_valid; d_we = s.d_we;       d_addr = s.d_addr;
        d_wdata = s.d_wdata;
    endtask

    // One clock: drive, check at negedge against the model, advance the model at posedge.
    task automatic step(input stim_t s);
        bit preq, dw, gp, gd, erd, ewr;
        logic [AW-1:0] ea;
        logic [DW-1:0] nxt;
        drive(s);
        @(negedge clk);
        preq = s.p_rd || s.p_wr;
        dw = (m_wait >= MW) || (RR && m_last == 1);
        gp = rst_n && preq && !(s.d_valid && dw);
        gd = rst_n && s.d_valid && (!preq || dw);
        erd = gp ? (s.p_rd && !s.p_wr) : (gd && !s.d_we);
        ewr = gp ? s.p_wr : (gd && s.d_we);
        ea = gp ? s.p_addr : s.d_addr;
        chk("p_stall", 64'(p_stall), 64'(rst_n && preq && !gp));
        chk("d_ready", 64'(d_ready), 64'(gd));
        chk("mem_rd", 64'(mem_rd), 64'(erd));
        chk("mem_wr", 64'(mem_wr), 64'(ewr));
        if (gp || gd) begin
            chk("mem_addr", 64'(mem_addr), 64'(ea));
            chk("mem_func3", 64'(mem_func3), 64'(gp ? s.p_f3 : FUNC3_WORD));
            if (ewr) chk("mem_wdata", 64'(mem_wdata), 64'(gp ? s.p_wdata : s.d_wdata));
        end
        chk("p_rvalid", 64'(p_rvalid), 64'(m_tp));
        chk("d_rvalid", 64'(d_rvalid), 64'(m_td));
        chk("rvalid_excl", 64'(p_rvalid & d_rvalid), 64'(0));
        if (m_tp || m_td) chk("rdata", 64'(rdata), 64'(m_rdata));
        nxt = mem[ea];
        obs_ready = d_ready;
        obs_stall = p_stall;
        obs_prv = p_rvalid;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (gp) m_last = 1;
            else if (gd) m_last = 2;
            m_wait = (s.d_valid && !gd) ? m_wait + 1 : 0;
            m_tp = gp && erd;
            m_td = gd && erd;
            m_gd = gd;
            m_rdata = nxt;
        end
        #1;
    endtask

    task automatic do_reset();
        stim_t z;
        z = '{default: '0};
        rst_n = 1'b0;
        step(z);
        rst_n = 1'b1;
    endtask

    vec_t  tbl[8];
    stim_t s, idle;
    int    first, stalls, r;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        idle = '{default: '0};
        model_reset();
        drive(idle);
        @(posedge clk);
        #1;

        // Requests are active during reset; every output must still read 0
        s = idle;
        s.p_rd = 1; s.d_valid = 1; s.d_we = 1;
        step(s);
        step(s);
        rst_n = 1'b1;

        tbl[0] = '{s: '{1, 0, 9'h010, 0, 3'b010, 0, 0, 0, 0},
                   stall: 0, ready: 0, mrd: 1, mwr: 0, prv: 0, drv: 0};
        tbl[1] = '{s: '{0, 0, 0, 0, 0, 1, 1, 9'h020, 32'hDEADBEEF},
                   stall: 0, ready: 1, mrd: 0, mwr: 1, prv: 1, drv: 0};
        tbl[2] = '{s: '{1, 0, 9'h020, 0, 3'b100, 1, 0, 9'h030, 0},
                   stall: 0, ready: 0, mrd: 1, mwr: 0, prv: 0, drv: 0};
        tbl[3] = '{s: '{0, 0, 0, 0, 0, 1, 0, 9'h030, 0},
                   stall: 0, ready: 1, mrd: 1, mwr: 0, prv: 1, drv: 0};
        tbl[4] = '{s: idle, stall: 0, ready: 0, mrd: 0, mwr: 0, prv: 0, drv: 1};
        tbl[5] = '{s: '{0, 1, 9'h040, 32'h0BADF00D, 3'b001, 0, 0, 0, 0},
                   stall: 0, ready: 0, mrd: 0, mwr: 1, prv: 0, drv: 0};
        tbl[6] = '{s: '{0, 0, 0, 0, 0, 1, 1, 9'h041, 32'h13572468},
                   stall: 0, ready: 1, mrd: 0, mwr: 1, prv: 0, drv: 0};
        tbl[7] = '{s: '{0, 1, 9'h042, 32'h55AA55AA, 3'b010, 1, 0, 9'h043, 0},
                   stall: 0, ready: 0, mrd: 0, mwr: 1, prv: 0, drv: 0};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].s);
            chk("tbl_stall", 64'(obs_stall), 64'(tbl[i].stall));
            chk("tbl_ready", 64'(obs_ready), 64'(tbl[i].ready));
            chk("tbl_prv", 64'(obs_prv), 64'(tbl[i].prv));
        end
        step(idle);

`ifndef DMEM_ARB_RR_EN
        // P hammers the port; D must be forced through after exactly MW waiting cycles
        do_reset();
        first = -1;
        stalls = 0;
        s = idle;
        s.d_valid = 1; s.d_we = 1; s.d_addr = 9'h100; s.d_wdata = 32'h12345678;
        for (int i = 0; i < 12; i++) begin
            if (first >= 0) s.d_valid = 0;
            s.p_rd = 1;
            s.p_addr = AW'(i);
            step(s);
            if (obs_ready && first < 0) first = i;
            if (obs_stall) stalls++;
        end
        chk("fixed_first_ready", 64'(first), 64'(MW));
        chk("fixed_stall_count", 64'(stalls), 64'(1));
`else
        // Continuous contention alternates P, D, P, D from idle
        do_reset();
        s = idle;
        s.p_rd = 1; s.d_valid = 1; s.d_we = 0;
        for (int i = 0; i < 8; i++) begin
            s.p_addr = AW'(2 * i);
            s.d_addr = AW'(2 * i + 1);
            step(s);
            chk("rr_ready", 64'(obs_ready), 64'(i % 2));
            chk("rr_stall", 64'(obs_stall), 64'(i % 2));
        end
`endif

        // Alternating owners: responses alternate, one per cycle
        for (int i = 0; i < 8; i++) begin
            s = idle;
            if (i % 2 == 0) begin
                s.p_rd = 1; s.p_addr = AW'(i);
            end else begin
                s.d_valid = 1; s.d_addr = AW'(i);
            end
            step(s);
            if (i > 0) chk("alt_prv", 64'(obs_prv), 64'(i % 2));
        end
        step(idle);

        // Reset asserted mid-cycle over a granted P read, with D left waiting
        s = idle;
        s.p_rd = 1; s.d_valid = 1; s.d_we = 1; s.d_addr = 9'h077;
        step(s);
        s = idle;
        s.p_rd = 1; s.p_addr = 9'h055;
        drive(s);
        @(negedge clk);
        chk("rst_pre_mem_rd", 64'(mem_rd), 64'(1));
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_p_rvalid", 64'(p_rvalid), 64'(0));
        chk("rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
        chk("rst_wait_cnt", 64'(dut.u_wait_cnt.cnt_q), 64'(0));
        chk("rst_mem_rd", 64'(mem_rd), 64'(0));
        chk("rst_p_stall", 64'(p_stall), 64'(0));
        drive(idle);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic; D holds its payload until the model says it was accepted
        s = idle;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 2);
            s.p_rd = (r == 1);
            s.p_wr = (r == 2);
            s.p_addr = AW'($urandom_range(0, 31));
            s.p_wdata = $urandom;
            s.p_f3 = 3'($urandom_range(0, 7));
            if (!(s.d_valid && !m_gd)) begin
                s.d_valid = ($urandom_range(0, 2) != 0);
                s.d_we = 1'($urandom_range(0, 1));
                s.d_addr = AW'($urandom_range(0, 31));
                s.d_wdata = $urandom;
            end
            step(s);
        end
        step(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
